// File: rtl/mdio_pkg.sv
// Purpose: shared types and constants for the MDIO APB master.
// Contents: FSM state enum, Clause-22 frame constants, latched request
//           payload struct, and a helper that assembles a 64-bit frame.
package mdio_pkg;

    localparam int unsigned PREAMBLE_LEN  = 32;
    localparam int unsigned FRAME_LEN     = 64;
    localparam logic [1:0]  ST            = 2'b01;
    localparam logic [1:0]  OP_WR         = 2'b01;
    localparam logic [1:0]  OP_RD         = 2'b10;
    localparam logic [1:0]  TA_WR         = 2'b10;
    localparam logic [15:0] BUS_NONE_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Request captured on the accept cycle.
    typedef struct packed {
        logic [3:0]  bus;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic        write;
        logic [15:0] wdata;
    } mdio_req_t;

    // Frame word, MSB transmitted first. On reads the TA/data field is
    // filled with ones; the line is released there anyway.
    function automatic logic [FRAME_LEN-1:0] build_frame(input mdio_req_t req);
        logic [1:0]  op;
        logic [17:0] tail;
        op   = req.write ? OP_WR : OP_RD;
        tail = req.write ? {TA_WR, req.wdata} : 18'h3FFFF;
        return {{PREAMBLE_LEN{1'b1}}, ST, op, req.phyad, req.regad, tail};
    endfunction

endpackage

// File: rtl/mdio_apb_master_if.sv
// Purpose: APB-style request/response bundle for the MDIO master.
// Signals: paddr/pwrite/psel/penable/pwdata (request, master->slave),
//          prdata/pready (response, slave->master).
interface mdio_apb_master_if;
    logic [15:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/mdio_clk_div.sv
// Purpose: MDC generator. Each bit is DIV clk cycles low then DIV high.
// Ports: clk, rst (async, active-high), i_en (run while a frame is active),
//        o_mdc (registered MDC), o_rise_c (this edge raises MDC: sample point),
//        o_fall_c (this edge lowers MDC: next bit starts).
module mdio_clk_div #(
    parameter int unsigned DIV = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_mdc,
    output logic o_rise_c,
    output logic o_fall_c
);
    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] r_cnt;
    logic        r_mdc;
    logic        w_last;

    assign w_last   = i_en && (r_cnt == LAST);
    assign o_rise_c = w_last && !r_mdc;
    assign o_fall_c = w_last && r_mdc;
    assign o_mdc    = r_mdc;

    // Half-period counter; held cleared while disabled so every frame starts low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 16'd0;
            r_mdc <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= 16'd0;
            r_mdc <= 1'b0;
        end else if (w_last) begin
            r_cnt <= 16'd0;
            r_mdc <= !r_mdc;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/mdio_apb_master.sv
// Purpose: single-request APB front end issuing Clause-22 MDIO frames on one
//          of NBUS buses sharing a common MDC.
// Ports: clk, rst (async, active-high); apb (slave modport: paddr, pwrite,
//        psel, penable, pwdata in; prdata, pready out); mdc (shared clock),
//        mdo/mdt (per-bus data and tristate, 1 = high-Z), mdi (per-bus input).
module mdio_apb_master
    import mdio_pkg::*;
#(
    parameter int unsigned DIV  = 10000,
    parameter int unsigned NBUS = 5
) (
    input  logic                clk,
    input  logic                rst,
    mdio_apb_master_if.slave    apb,
    output logic                mdc,
    output logic [NBUS-1:0]     mdo,
    input  logic [NBUS-1:0]     mdi,
    output logic [NBUS-1:0]     mdt
);
    localparam logic [5:0] LAST_BIT  = 6'(FRAME_LEN - 1);
    localparam logic [5:0] TRI_START = 6'd46;
    localparam logic [5:0] RX_START  = 6'd48;

    state_t          r_state, w_state_nxt;
    mdio_req_t       r_req, w_req_nxt, w_req_in;
    logic [5:0]      r_bit, w_bit_nxt;
    logic [63:0]     r_frame, w_frame_nxt;
    logic [NBUS-1:0] r_mdo, w_mdo_nxt, r_mdt, w_mdt_nxt;
    logic [15:0]     r_rx, w_rx_nxt, r_prdata, w_prdata_nxt;
    logic            r_pready, w_pready_nxt;

    logic            w_mdc, w_rise, w_fall, w_mdi_sel, w_bus_ok;
    logic            w_drive, w_drive_mdo, w_drive_mdt;
    logic [3:0]      w_drive_bus;
    logic            w_unused;

    assign w_req_in = '{bus:   apb.paddr[15:12],
                        phyad: apb.paddr[11:7],
                        regad: apb.paddr[5:1],
                        write: apb.pwrite,
                        wdata: apb.pwdata};
    assign w_unused = &{1'b0, apb.penable, apb.paddr[6], apb.paddr[0]};
    assign w_bus_ok = 32'(r_req.bus) < NBUS;

    mdio_clk_div #(.DIV(DIV)) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_state == FRAME),
        .o_mdc    (w_mdc),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    // Input bit of the selected bus; an out-of-range select reads as idle high.
    always_comb begin
        w_mdi_sel = 1'b1;
        for (int unsigned i = 0; i < NBUS; i++) begin
            if (r_req.bus == 4'(i)) w_mdi_sel = mdi[i];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_bit_nxt    = r_bit;
        w_frame_nxt  = r_frame;
        w_mdo_nxt    = r_mdo;
        w_mdt_nxt    = r_mdt;
        w_rx_nxt     = r_rx;
        w_prdata_nxt = r_prdata;
        w_pready_nxt = 1'b0;
        w_drive      = 1'b0;
        w_drive_bus  = r_req.bus;
        w_drive_mdo  = 1'b1;
        w_drive_mdt  = 1'b1;

        unique case (r_state)
            IDLE: begin
                if (apb.psel) begin
                    w_state_nxt = FRAME;
                    w_req_nxt   = w_req_in;
                    w_frame_nxt = build_frame(w_req_in);
                    w_bit_nxt   = 6'd0;
                    w_rx_nxt    = 16'd0;
                    w_drive     = 1'b1;
                    w_drive_bus = w_req_in.bus;
                    w_drive_mdo = w_frame_nxt[FRAME_LEN-1];
                    w_drive_mdt = 1'b0;
                end
            end
            FRAME: begin
                if (w_rise && (r_bit >= RX_START)) begin
                    w_rx_nxt = {r_rx[14:0], w_mdi_sel};
                end
                if (w_fall) begin
                    if (r_bit == LAST_BIT) begin
                        w_state_nxt  = DONE;
                        w_pready_nxt = 1'b1;
                        w_bit_nxt    = 6'd0;
                        w_mdo_nxt    = '1;
                        w_mdt_nxt    = '1;
                        if (!r_req.write) begin
                            w_prdata_nxt = w_bus_ok ? r_rx : BUS_NONE_DATA;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + 6'd1;
                        w_frame_nxt = {r_frame[62:0], 1'b0};
                        w_drive     = 1'b1;
                        w_drive_mdo = r_frame[62];
                        // Release the line from the TA bit onward on reads.
                        w_drive_mdt = !r_req.write && ((r_bit + 6'd1) >= TRI_START);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Only the selected bus follows the frame; the rest stay idle-high.
        if (w_drive) begin
            w_mdo_nxt = '1;
            w_mdt_nxt = '1;
            for (int unsigned i = 0; i < NBUS; i++) begin
                if (w_drive_bus == 4'(i)) begin
                    w_mdo_nxt[i] = w_drive_mdo;
                    w_mdt_nxt[i] = w_drive_mdt;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_req    <= '0;
            r_bit    <= 6'd0;
            r_frame  <= 64'd0;
            r_mdo    <= '1;
            r_mdt    <= '1;
            r_rx     <= 16'd0;
            r_prdata <= 16'd0;
            r_pready <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_bit    <= w_bit_nxt;
            r_frame  <= w_frame_nxt;
            r_mdo    <= w_mdo_nxt;
            r_mdt    <= w_mdt_nxt;
            r_rx     <= w_rx_nxt;
            r_prdata <= w_prdata_nxt;
            r_pready <= w_pready_nxt;
        end
    end

    assign mdc        = w_mdc;
    assign mdo        = r_mdo;
    assign mdt        = r_mdt;
    assign apb.prdata = r_prdata;
    assign apb.pready = r_pready;
endmodule

// File: tb/tb_mdio_apb_master.sv
// Purpose: directed + randomized bench for mdio_apb_master (DIV=4, NBUS=5).
// Every clk cycle of each frame is compared against a bit-list model of the
// Clause-22 frame; a PHY model drives read data on the selected bus.
module tb_mdio_apb_master;
    localparam int unsigned DIV  = 4;
    localparam int unsigned NBUS = 5;
    localparam int          BITC = 2 * DIV;

    logic            clk = 1'b0;
    logic            rst;
    logic            mdc;
    logic [NBUS-1:0] mdo, mdi, mdt;

    int              errors = 0;
    int              checks = 0;
    logic [15:0]     exp_prdata;

    mdio_apb_master_if apb ();

    mdio_apb_master #(.DIV(DIV), .NBUS(NBUS)) dut (
        .clk (clk),
        .rst (rst),
        .apb (apb),
        .mdc (mdc),
        .mdo (mdo),
        .mdi (mdi),
        .mdt (mdt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit b of the frame as listed field by field (index 0 = first on the wire).
    function automatic logic [63:0] ref_frame(input logic [15:0] addr, input logic wr,
                                              input logic [15:0] wd);
        bit q[$];
        logic [63:0] r;
        for (int i = 0; i < 32; i++) q.push_back(1'b1);
        q.push_back(1'b0); q.push_back(1'b1);
        if (wr) begin q.push_back(1'b0); q.push_back(1'b1); end
        else    begin q.push_back(1'b1); q.push_back(1'b0); end
        for (int i = 11; i >= 7; i--) q.push_back(addr[i]);
        for (int i = 5; i >= 1; i--) q.push_back(addr[i]);
        if (wr) begin
            q.push_back(1'b1); q.push_back(1'b0);
            for (int i = 15; i >= 0; i--) q.push_back(wd[i]);
        end else begin
            for (int i = 0; i < 18; i++) q.push_back(1'b1);
        end
        for (int i = 0; i < 64; i++) r[i] = q[i];
        return r;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_mdc"},    32'(mdc), 32'd0);
        check({tag, "_mdo"},    32'(mdo), 32'(NBUS'('1)));
        check({tag, "_mdt"},    32'(mdt), 32'(NBUS'('1)));
        check({tag, "_pready"}, 32'(apb.pready), 32'd0);
        check({tag, "_prdata"}, 32'(apb.prdata), 32'(exp_prdata));
    endtask

    // Issue one request from an IDLE cycle and follow it cycle by cycle.
    // abort_bit >= 0 pulses rst at the start of that bit. nx_* are presented
    // during the pready cycle.
    task automatic run_txn(input logic [15:0] addr, input logic wr, input logic [15:0] wd,
                           input logic [15:0] phy, input int abort_bit,
                           input logic nx_psel, input logic [15:0] nx_addr,
                           input logic nx_wr, input logic [15:0] nx_wd);
        logic [63:0]     bits;
        logic [NBUS-1:0] emdo, emdt, mask;
        int              bus, b, ph;
        bus  = int'(addr[15:12]);
        bits = ref_frame(addr, wr, wd);
        apb.psel    = 1'b1;
        apb.paddr   = addr;
        apb.pwrite  = wr;
        apb.pwdata  = wd;
        apb.penable = 1'($urandom);
        @(posedge clk); #1;
        for (int k = 0; k < 512; k++) begin
            b  = k / BITC;
            ph = k % BITC;
            // Request inputs are scrambled while the frame runs.
            apb.paddr   = 16'($urandom);
            apb.pwrite  = 1'($urandom);
            apb.pwdata  = 16'($urandom);
            apb.penable = 1'($urandom);
            apb.psel    = nx_psel ? 1'b1 : 1'($urandom);
            emdo = '1; emdt = '1; mask = '1;
            if (bus < int'(NBUS)) begin
                emdt[bus] = !wr && (b >= 46);
                emdo[bus] = bits[b];
                mask[bus] = !emdt[bus];
            end
            check("frame_mdc", 32'(mdc), 32'(ph >= int'(DIV)));
            check("frame_mdt", 32'(mdt), 32'(emdt));
            check("frame_mdo", 32'(mdo & mask), 32'(emdo & mask));
            check("frame_pready", 32'(apb.pready), 32'd0);
            check("frame_prdata", 32'(apb.prdata), 32'(exp_prdata));
            mdi = NBUS'($urandom);
            if (bus < int'(NBUS) && b >= 48) mdi[bus] = phy[63 - b];
            if (b == abort_bit && ph == 0) begin
                apb.psel = 1'b0;
                rst = 1'b1;
                exp_prdata = 16'h0000;
                #1;
                check_idle("abort_async");
                @(posedge clk); #1;
                check_idle("abort");
                rst = 1'b0;
                for (int j = 0; j < 4 * BITC; j++) begin
                    @(posedge clk); #1;
                    check_idle("post_abort");
                end
                return;
            end
            @(posedge clk); #1;
        end
        if (!wr) exp_prdata = (bus < int'(NBUS)) ? phy : 16'hFFFF;
        check("done_pready", 32'(apb.pready), 32'd1);
        check("done_prdata", 32'(apb.prdata), 32'(exp_prdata));
        check("done_mdc", 32'(mdc), 32'd0);
        check("done_mdo", 32'(mdo), 32'(NBUS'('1)));
        check("done_mdt", 32'(mdt), 32'(NBUS'('1)));
        apb.psel   = nx_psel;
        apb.paddr  = nx_addr;
        apb.pwrite = nx_wr;
        apb.pwdata = nx_wd;
        @(posedge clk); #1;
        check_idle("post_done");
    endtask

    initial begin
        logic [15:0] a;
        logic        w;
        rst         = 1'b1;
        apb.psel    = 1'b0;
        apb.paddr   = 16'h0000;
        apb.pwrite  = 1'b0;
        apb.pwdata  = 16'h0000;
        apb.penable = 1'b0;
        mdi         = '1;
        exp_prdata  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("idle");

        // Write on bus 0, PHY 1, reg 30.
        run_txn(16'h00BC, 1'b1, 16'hA001, 16'h0000, -1, 1'b0, 16'h0, 1'b0, 16'h0);
        // Read on bus 2 returning 0x1234.
        run_txn(16'h213E, 1'b0, 16'h0000, 16'h1234, -1, 1'b0, 16'h0, 1'b0, 16'h0);
        // Back-to-back: psel stays high, new address presented in the pready cycle.
        run_txn(16'h1A5A, 1'b1, 16'h5A5A, 16'h0000, -1, 1'b1, 16'h3C84, 1'b0, 16'h0);
        run_txn(16'h3C84, 1'b0, 16'h0000, 16'hC0DE, -1, 1'b0, 16'h0, 1'b0, 16'h0);
        for (int j = 0; j < 3 * BITC; j++) begin
            @(posedge clk); #1;
            check_idle("no_dup");
        end
        // Read with a bus select beyond NBUS.
        run_txn(16'h7092, 1'b0, 16'h0000, 16'h5555, -1, 1'b0, 16'h0, 1'b0, 16'h0);
        // Reset in the middle of a write, then a normal read.
        run_txn(16'h0C46, 1'b1, 16'hFFFF, 16'h0000, 40, 1'b0, 16'h0, 1'b0, 16'h0);
        run_txn(16'h1F3E, 1'b0, 16'h0000, 16'hBEEF, -1, 1'b0, 16'h0, 1'b0, 16'h0);
        // Randomized requests, including out-of-range bus selects.
        for (int n = 0; n < 6; n++) begin
            a        = 16'($urandom);
            a[15:12] = 4'($urandom_range(0, 7));
            w        = 1'($urandom);
            run_txn(a, w, 16'($urandom), 16'($urandom), -1, 1'b0, 16'h0, 1'b0, 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
